// File: rtl/stop_watch_lap.sv
// ---------------------------------------------------------------------------
// stop_watch_lap
//
// Purpose:
//   NDIG-digit BCD stopwatch. A DVSR-cycle divider generates count ticks.
//   Counting can go up (wrapping from all-9s to 0 with a one-cycle flag) or
//   down (expiring at zero). A preset can be loaded, and a lap register can
//   freeze the displayed value while the live count keeps running. Every
//   output comes straight from a flop.
//
// Parameters:
//   NDIG  number of BCD digits (1..8)
//   DVSR  clock cycles per count tick (>=1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   go          level: 1 = count, 0 = pause
//   clr         clears count, tick phase, lap and expiry
//   up          count direction, 1 = up, 0 = down
//   load        pulse: load preset (digits above 9 saturate to 9)
//   preset      BCD preset, digit i at [4i+3:4i]
//   lap         pulse: toggle lap freeze
//   bcd         live count, digit 0 least significant
//   disp        frozen lap value while lap_active, otherwise equal to bcd
//   running     stopwatch is in RUN
//   expired     stopwatch is in EXPIRED
//   wrap        one-cycle pulse after an up-count rollover to zero
//   lap_active  display is frozen
// ---------------------------------------------------------------------------
module stop_watch_lap #(
  parameter int NDIG = 4,
  parameter int DVSR = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              clr,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] preset,
  input  logic              lap,
  output logic [4*NDIG-1:0] bcd,
  output logic [4*NDIG-1:0] disp,
  output logic              running,
  output logic              expired,
  output logic              wrap,
  output logic              lap_active
);

  localparam int W  = 4 * NDIG;
  localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  // BCD ripple increment: a 9 becomes 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD ripple decrement: a 0 becomes 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Clamp any non-decimal preset digit (A..F) to 9.
  function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_all_nines(input logic [W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] != 4'd9) begin
        r = 1'b0;
      end
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [W-1:0]  bcd_q, bcd_d;
  logic [W-1:0]  disp_q, disp_d;
  logic          lap_q, lap_d;
  logic          wrap_q, wrap_d;
  logic          running_q, expired_q;
  logic          tick;
  logic [W-1:0]  bcd_step;

  // Next-state logic. clr and load both abandon any pending tick; lap is
  // still honoured on a tick edge, so a capture sees the post-tick count.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bcd_d    = bcd_q;
    lap_d    = lap_q;
    wrap_d   = 1'b0;
    tick     = (state_q == ST_RUN) && (tick_q == TICK_LAST);
    bcd_step = up ? bcd_inc(bcd_q) : bcd_dec(bcd_q);

    if (clr) begin
      state_d = ST_STOP;
      tick_d  = '0;
      bcd_d   = '0;
      lap_d   = 1'b0;
    end else if (load) begin
      state_d = ST_STOP;
      tick_d  = '0;
      bcd_d   = bcd_sat(preset);
    end else begin
      if (lap) begin
        lap_d = ~lap_q;
      end

      // The divider only advances in RUN, so a pause keeps the tick phase.
      if (state_q == ST_RUN) begin
        tick_d = tick ? '0 : tick_q + 1'b1;
      end

      if (tick) begin
        bcd_d  = bcd_step;
        wrap_d = up && bcd_all_nines(bcd_q);
      end

      // A down tick landing on zero expires even if go drops on the same
      // edge; otherwise dropping go pauses after taking any due tick.
      case (state_q)
        ST_STOP: begin
          if (go) begin
            state_d = (!up && (bcd_q == '0)) ? ST_EXPIRED : ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick && !up && (bcd_step == '0)) begin
            state_d = ST_EXPIRED;
          end else if (!go) begin
            state_d = ST_STOP;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: begin
          state_d = ST_STOP;
        end
      endcase
    end

    // disp only holds while the freeze is active both before and after
    // this edge; capture, release and clear all take the new count.
    disp_d = (lap_q && lap_d) ? disp_q : bcd_d;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      tick_q    <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      lap_q     <= lap_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= (state_d == ST_EXPIRED);
    end
  end

  assign bcd        = bcd_q;
  assign disp       = disp_q;
  assign running    = running_q;
  assign expired    = expired_q;
  assign wrap       = wrap_q;
  assign lap_active = lap_q;

endmodule
